// File: rtl/data_path_pkg.sv
// Shared types and ALU opcode constants for the single-bus datapath.
package data_path_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;
    typedef logic [4:0]  alu_op_t;

    localparam alu_op_t OP_ADD  = 5'b00011;
    localparam alu_op_t OP_SUB  = 5'b00100;
    localparam alu_op_t OP_SHR  = 5'b00101;
    localparam alu_op_t OP_SHRA = 5'b00110;
    localparam alu_op_t OP_SHL  = 5'b00111;
    localparam alu_op_t OP_ROR  = 5'b01000;
    localparam alu_op_t OP_ROL  = 5'b01001;
    localparam alu_op_t OP_AND  = 5'b01010;
    localparam alu_op_t OP_OR   = 5'b01011;
    localparam alu_op_t OP_MUL  = 5'b01111;
    localparam alu_op_t OP_DIV  = 5'b10000;
    localparam alu_op_t OP_NEG  = 5'b10001;
    localparam alu_op_t OP_NOT  = 5'b10010;

    // Zero-extend a 32-bit word into the low half of a 64-bit result.
    function automatic dword_t zext(input word_t v);
        return {32'h0, v};
    endfunction

    // Sign-extend a 32-bit word to 64 bits.
    function automatic dword_t sext(input word_t v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A (from Y) op B (from bus) -> 64-bit result.
import data_path_pkg::*;

module data_path_alu (
    input  alu_op_t    op_i,
    input  word_t      a_i,
    input  word_t      b_i,
    input  logic       cin_i,
    output dword_t     r_o
);

    logic [4:0]         shamt;
    logic [32:0]        sum33;
    word_t              diff;
    word_t              shra_w;
    dword_t             dbl;
    dword_t             dbl_r;
    dword_t             dbl_l;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] prod;
    logic signed [31:0] quo;
    logic signed [31:0] rem;

    assign shamt = b_i[4:0];

    // Intermediate arithmetic terms shared by several opcodes.
    always_comb begin
        sum33  = {1'b0, a_i} + {1'b0, b_i} + {32'h0, cin_i};
        diff   = a_i - b_i;
        shra_w = word_t'($signed(a_i) >>> shamt);
        dbl    = {a_i, a_i};
        dbl_r  = dbl >> shamt;
        dbl_l  = dbl << shamt;
        sa64   = $signed(sext(a_i));
        sb64   = $signed(sext(b_i));
        prod   = sa64 * sb64;
    end

    // Signed division; zero divisor yields zero, and -1 is handled
    // explicitly so the most-negative dividend wraps instead of trapping.
    always_comb begin
        quo = '0;
        rem = '0;
        if (b_i == 32'h0) begin
            quo = '0;
            rem = '0;
        end else if (b_i == 32'hFFFF_FFFF) begin
            quo = -$signed(a_i);
            rem = '0;
        end else begin
            quo = $signed(a_i) / $signed(b_i);
            rem = $signed(a_i) % $signed(b_i);
        end
    end

    // Opcode select; unknown opcodes produce zero.
    always_comb begin
        r_o = '0;
        unique case (op_i)
            OP_ADD:  r_o = {31'h0, sum33};
            OP_SUB:  r_o = sext(diff);
            OP_SHR:  r_o = zext(a_i >> shamt);
            OP_SHRA: r_o = zext(shra_w);
            OP_SHL:  r_o = zext(a_i << shamt);
            OP_ROR:  r_o = zext(dbl_r[31:0]);
            OP_ROL:  r_o = zext(dbl_l[63:32]);
            OP_AND:  r_o = zext(a_i & b_i);
            OP_OR:   r_o = zext(a_i | b_i);
            OP_MUL:  r_o = dword_t'(prod);
            OP_DIV:  r_o = {word_t'(rem), word_t'(quo)};
            OP_NEG:  r_o = zext(-b_i);
            OP_NOT:  r_o = zext(~b_i);
            default: r_o = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: PC, IR, MAR, MDR, R1-R15, HI/LO, Y and Z
// share one 32-bit bus; control strobes come from outside.
import data_path_pkg::*;

module data_path (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCout,
    input  logic        ZHighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  AND,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        Cin,
    input  logic [31:0] Mdatain
);

    word_t  PC, IR, MAR, MDR, Y, ZHigh, ZLow, HI, LO;
    word_t  R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
    word_t  gpr_q [1:15];
    logic [15:1] gpr_in;

    word_t  bus;
    word_t  PC_d;
    word_t  MDR_d;
    dword_t alu_r;

    assign gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in};

    // Named views of the register file for hierarchical probing.
    assign R1  = gpr_q[1];
    assign R2  = gpr_q[2];
    assign R3  = gpr_q[3];
    assign R4  = gpr_q[4];
    assign R5  = gpr_q[5];
    assign R6  = gpr_q[6];
    assign R7  = gpr_q[7];
    assign R8  = gpr_q[8];
    assign R9  = gpr_q[9];
    assign R10 = gpr_q[10];
    assign R11 = gpr_q[11];
    assign R12 = gpr_q[12];
    assign R13 = gpr_q[13];
    assign R14 = gpr_q[14];
    assign R15 = gpr_q[15];

    // Priority bus mux; an idle bus reads as zero.
    always_comb begin
        bus = '0;
        if (PCout)         bus = PC;
        else if (MDRout)   bus = MDR;
        else if (ZHighout) bus = ZHigh;
        else if (Zlowout)  bus = ZLow;
        else if (R2out)    bus = R2;
        else if (R3out)    bus = R3;
    end

    // PC and MDR next-state: increment beats a bus load; MDR picks memory or bus.
    always_comb begin
        PC_d = PC;
        if (IncPC)     PC_d = PC + 32'd1;
        else if (PCin) PC_d = bus;
        MDR_d = MDR;
        if (MDRin)     MDR_d = Read ? Mdatain : bus;
    end

    data_path_alu u_alu (
        .op_i  (AND),
        .a_i   (Y),
        .b_i   (bus),
        .cin_i (Cin),
        .r_o   (alu_r)
    );

    // Special-purpose registers; Clear overrides every enable.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            PC  <= '0;
            IR  <= '0;
            MAR <= '0;
            MDR <= '0;
            Y   <= '0;
            HI  <= '0;
            LO  <= '0;
        end else begin
            PC  <= PC_d;
            MDR <= MDR_d;
            if (IRin)  IR  <= bus;
            if (MARin) MAR <= bus;
            if (Yin)   Y   <= bus;
            if (HIin)  HI  <= bus;
            if (LOin)  LO  <= bus;
        end
    end

    // Z halves capture the ALU result independently and hold otherwise.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            ZHigh <= '0;
            ZLow  <= '0;
        end else begin
            if (ZHighIn) ZHigh <= alu_r[63:32];
            if (ZLowIn)  ZLow  <= alu_r[31:0];
        end
    end

    // General registers R1-R15, all loaded from the same bus value.
    always_ff @(posedge Clock) begin
        for (int i = 1; i <= 15; i++) begin
            if (!Clear)         gpr_q[i] <= '0;
            else if (gpr_in[i]) gpr_q[i] <= bus;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: hand-computed expectations, internal probes.
module tb_data_path;

    logic        Clock, Clear;
    logic        PCout, ZHighout, Zlowout, MDRout, R2out, R3out;
    logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [4:0]  AND;
    logic        R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
    logic        R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
    logic [31:0] Mdatain;

    int n_tests = 0;
    int n_fail  = 0;

    data_path dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(R2out), .R3out(R3out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .AND(AND),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
        .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in),
        .R11in(R11in), .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .Cin(Cin), .Mdatain(Mdatain)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0;
        MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
        AND = 5'b0;
        R1in = 0; R2in = 0; R3in = 0; R4in = 0; R5in = 0; R6in = 0; R7in = 0; R8in = 0;
        R9in = 0; R10in = 0; R11in = 0; R12in = 0; R13in = 0; R14in = 0; R15in = 0;
        HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
    endtask

    // One edge with the currently driven strobes, then drop them.
    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    // ALU op with Y as A and the given bus source as B, loading both Z halves.
    task automatic alu_op(input logic [4:0] op, input logic use_r3);
        AND = op; ZLowIn = 1; ZHighIn = 1;
        if (use_r3) R3out = 1; else MDRout = 1;
        tick();
    endtask

    initial begin
        idle();
        Mdatain = '0;
        Clear = 0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Clear = 1;
        chk("rst_pc", dut.PC, 32'h0);
        chk("rst_zlow", dut.ZLow, 32'h0);

        // register loads through MDR
        mem_to_mdr(32'h12); MDRout = 1; R2in = 1; tick();
        chk("r2_load", dut.R2, 32'h12);
        mem_to_mdr(32'h14); MDRout = 1; R3in = 1; tick();
        chk("r3_load", dut.R3, 32'h14);
        mem_to_mdr(32'h18); MDRout = 1; R1in = 1; tick();
        chk("r1_load", dut.R1, 32'h18);

        // AND: 0x12 & 0x14 = 0x10
        R2out = 1; Yin = 1; tick();
        chk("y_load", dut.Y, 32'h12);
        R3out = 1; AND = 5'b01010; ZLowIn = 1; tick();
        chk("and_zlow", dut.ZLow, 32'h10);
        Zlowout = 1; R1in = 1; tick();
        chk("and_r1", dut.R1, 32'h10);

        // fetch
        mem_to_mdr(32'h7); MDRout = 1; PCin = 1; tick();
        chk("pc_load", dut.PC, 32'h7);
        PCout = 1; MARin = 1; IncPC = 1; tick();
        chk("mar_pc", dut.MAR, 32'h7);
        chk("pc_inc", dut.PC, 32'h8);
        mem_to_mdr(32'h2891_8000); MDRout = 1; IRin = 1; tick();
        chk("ir_load", dut.IR, 32'h2891_8000);

        // arithmetic with Y=0x12, B=R3=0x14
        alu_op(5'b00011, 1);
        chk("add_lo", dut.ZLow, 32'h26);
        chk("add_hi", dut.ZHigh, 32'h0);
        Cin = 1; alu_op(5'b00011, 1);
        chk("addc_lo", dut.ZLow, 32'h27);
        alu_op(5'b01111, 1);
        chk("mul_lo", dut.ZLow, 32'h168);
        chk("mul_hi", dut.ZHigh, 32'h0);
        alu_op(5'b00100, 1);
        chk("sub_lo", dut.ZLow, 32'hFFFF_FFFE);
        chk("sub_hi", dut.ZHigh, 32'hFFFF_FFFF);
        alu_op(5'b01000, 1);
        chk("ror_lo", dut.ZLow, 32'h0001_2000);
        chk("ror_hi", dut.ZHigh, 32'h0);
        alu_op(5'b00111, 1);
        chk("shl_lo", dut.ZLow, 32'h0120_0000);
        alu_op(5'b11111, 1);
        chk("bad_op", dut.ZLow, 32'h0);
        alu_op(5'b01011, 1);
        // Z must hold with no load strobe
        R3out = 1; AND = 5'b00011; tick();
        chk("z_hold", dut.ZLow, 32'h16);

        // signed divide -7 / 2 -> q=-3, r=-1
        mem_to_mdr(32'hFFFF_FFF9); MDRout = 1; Yin = 1; tick();
        mem_to_mdr(32'h2);
        alu_op(5'b10000, 0);
        chk("div_q", dut.ZLow, 32'hFFFF_FFFD);
        chk("div_r", dut.ZHigh, 32'hFFFF_FFFF);
        mem_to_mdr(32'h0);
        alu_op(5'b10000, 0);
        chk("div0_lo", dut.ZLow, 32'h0);
        chk("div0_hi", dut.ZHigh, 32'h0);

        // simultaneous strobes: PC wins the bus, IncPC wins over PCin
        mem_to_mdr(32'h55);
        PCout = 1; MDRout = 1; R4in = 1; tick();
        chk("bus_prio", dut.R4, 32'h8);
        MDRout = 1; PCin = 1; IncPC = 1; tick();
        chk("inc_prio", dut.PC, 32'h9);
        MDRout = 1; HIin = 1; R5in = 1; R15in = 1; tick();
        chk("hi_load", dut.HI, 32'h55);
        chk("r15_load", dut.R15, 32'h55);
        R2out = 1; Yin = 1; tick();
        R3out = 1; AND = 5'b00011; ZLowIn = 1; ZHighIn = 1; tick();
        Zlowout = 1; LOin = 1; tick();
        chk("lo_load", dut.LO, 32'h26);

        // Clear overrides active enables
        Clear = 0;
        Mdatain = 32'hDEAD_BEEF; Read = 1; MDRin = 1; IncPC = 1; MDRout = 1;
        Yin = 1; IRin = 1; MARin = 1; HIin = 1; LOin = 1; R2in = 1; R7in = 1;
        AND = 5'b00011; ZLowIn = 1; ZHighIn = 1;
        tick();
        Clear = 1;
        chk("clr_pc", dut.PC, 32'h0);
        chk("clr_ir", dut.IR, 32'h0);
        chk("clr_mar", dut.MAR, 32'h0);
        chk("clr_mdr", dut.MDR, 32'h0);
        chk("clr_y", dut.Y, 32'h0);
        chk("clr_z", dut.ZHigh | dut.ZLow, 32'h0);
        chk("clr_hilo", dut.HI | dut.LO, 32'h0);
        chk("clr_gpr", dut.R1 | dut.R2 | dut.R3 | dut.R4 | dut.R5 | dut.R6 | dut.R7 |
                       dut.R8 | dut.R9 | dut.R10 | dut.R11 | dut.R12 | dut.R13 |
                       dut.R14 | dut.R15, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
